// File: rtl/sw_input_port_if.sv
// sw_input_port_if: switch levels in, debounced levels and change events out.
// The DUT takes the slave side; a driver or bench takes the master side.
interface sw_input_port_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] sw_raw;
    logic             ev_ack;
    logic [WIDTH-1:0] sw;
    logic [WIDTH-1:0] sw_event;
    logic             ev_valid;

    modport master (
        output sw_raw,
        output ev_ack,
        input  sw,
        input  sw_event,
        input  ev_valid
    );

    modport slave (
        input  sw_raw,
        input  ev_ack,
        output sw,
        output sw_event,
        output ev_valid
    );
endinterface

// File: rtl/sw_input_port.sv
// sw_input_port: synchronized, debounced switch inputs with sticky change events.
// Define SW_DEBOUNCE_EN to compile in the per-bit debounce hold counters.
module sw_input_port #(
    parameter int WIDTH     = 8,
    parameter int DB_CYCLES = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    sw_input_port_if.slave  bus
);
    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;
    logic [WIDTH-1:0] sw_q;
    logic [WIDTH-1:0] ev_q;
    logic [WIDTH-1:0] sw_d;
    logic [WIDTH-1:0] ev_d;
    logic [WIDTH-1:0] tog;

    // Hold counts outside 2..255 cannot be built sensibly.
    if (DB_CYCLES < 2 || DB_CYCLES > 255) begin : g_db_range
        $error("sw_input_port: DB_CYCLES out of range");
    end

`ifdef SW_DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [CW-1:0] cnt_q [WIDTH];
    logic [CW-1:0] cnt_d [WIDTH];

    // Accept a new level only after it has differed from sw for DB_CYCLES edges.
    always_comb begin
        sw_d  = sw_q;
        cnt_d = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (s2_q[i] == sw_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                sw_d[i]  = s2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // Per-bit hold counters; reset discards any partial count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    // No filtering: the synchronized level is taken every edge.
    assign sw_d = s2_q;
`endif

    assign tog  = sw_d ^ sw_q;
    // A toggle on this edge beats a simultaneous acknowledge.
    assign ev_d = tog | (ev_q & ~{WIDTH{bus.ev_ack}});

    // Synchronizer, debounced level and sticky event registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
            sw_q <= '0;
            ev_q <= '0;
        end else begin
            s1_q <= bus.sw_raw;
            s2_q <= s1_q;
            sw_q <= sw_d;
            ev_q <= ev_d;
        end
    end

    assign bus.sw       = sw_q;
    assign bus.sw_event = ev_q;
    assign bus.ev_valid = |ev_q;
endmodule

// File: tb/tb_sw_input_port.sv
// tb_sw_input_port: directed vector table plus random stimulus against
// a run-length reference model of the switch debouncer.
module tb_sw_input_port;
    localparam int W  = 8;
    localparam int DB = 10;

    logic clk;
    logic rst_n;

    sw_input_port_if #(.WIDTH(W)) bus ();

    sw_input_port #(
        .WIDTH     (W),
        .DB_CYCLES (DB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: raw level delayed two samples, then per bit the
    // number of consecutive edges the delayed level disagreed with sw.
    logic [W-1:0] m_s1, m_s2, m_sw, m_ev;
    int           m_run [W];

    typedef struct {
        logic         rn;
        logic [W-1:0] raw;
        logic         ack;
        int           n;
        logic [W-1:0] sw;
        logic [W-1:0] ev;
        logic         v;
    } vec_t;

    vec_t tbl [$];

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rn, input logic [W-1:0] raw,
                              input logic ack);
        logic [W-1:0] t;
        t = '0;
        if (!rn) begin
            m_s1 = '0;
            m_s2 = '0;
            m_sw = '0;
            m_ev = '0;
            for (int b = 0; b < W; b++) m_run[b] = 0;
            return;
        end
        for (int b = 0; b < W; b++) begin
`ifdef SW_DEBOUNCE_EN
            if (m_s2[b] != m_sw[b]) begin
                m_run[b] = m_run[b] + 1;
                if (m_run[b] == DB) begin
                    t[b]     = 1'b1;
                    m_run[b] = 0;
                end
            end else begin
                m_run[b] = 0;
            end
`else
            t[b] = m_s2[b] != m_sw[b];
`endif
        end
        m_sw = m_sw ^ t;
        m_ev = t | (ack ? '0 : m_ev);
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    task automatic step(input logic rn, input logic [W-1:0] raw,
                        input logic ack);
        rst_n      = rn;
        bus.sw_raw = raw;
        bus.ev_ack = ack;
        @(posedge clk);
        model_edge(rn, raw, ack);
        #1;
        chk("model_sw", bus.sw, m_sw);
        chk("model_ev", bus.sw_event, m_ev);
        chk("model_valid", {7'd0, bus.ev_valid}, {7'd0, |m_ev});
    endtask

    initial begin
        logic [W-1:0] raw;
        logic         ack;
        logic         rn;

        rst_n      = 1'b0;
        bus.sw_raw = '0;
        bus.ev_ack = 1'b0;
        m_s1 = '0;
        m_s2 = '0;
        m_sw = '0;
        m_ev = '0;
        for (int b = 0; b < W; b++) m_run[b] = 0;

`ifdef SW_DEBOUNCE_EN
        tbl.push_back('{1'b0, 8'h00, 1'b0,  2, 8'h00, 8'h00, 1'b0});
        tbl.push_back('{1'b1, 8'h04, 1'b0, 11, 8'h00, 8'h00, 1'b0});
        tbl.push_back('{1'b1, 8'h04, 1'b0,  1, 8'h04, 8'h04, 1'b1});
        tbl.push_back('{1'b1, 8'h05, 1'b0,  5, 8'h04, 8'h04, 1'b1});
        tbl.push_back('{1'b1, 8'h04, 1'b0, 12, 8'h04, 8'h04, 1'b1});
        tbl.push_back('{1'b1, 8'h06, 1'b0, 11, 8'h04, 8'h04, 1'b1});
        tbl.push_back('{1'b1, 8'h06, 1'b1,  1, 8'h06, 8'h02, 1'b1});
        tbl.push_back('{1'b1, 8'h06, 1'b1,  1, 8'h06, 8'h00, 1'b0});
        tbl.push_back('{1'b1, 8'h06, 1'b1,  1, 8'h06, 8'h00, 1'b0});
        tbl.push_back('{1'b1, 8'hFF, 1'b0,  6, 8'h06, 8'h00, 1'b0});
        tbl.push_back('{1'b0, 8'hFF, 1'b0,  1, 8'h00, 8'h00, 1'b0});
        tbl.push_back('{1'b1, 8'hFF, 1'b0, 11, 8'h00, 8'h00, 1'b0});
        tbl.push_back('{1'b1, 8'hFF, 1'b0,  1, 8'hFF, 8'hFF, 1'b1});
        tbl.push_back('{1'b1, 8'hFF, 1'b1,  1, 8'hFF, 8'h00, 1'b0});
`else
        tbl.push_back('{1'b0, 8'h00, 1'b0,  2, 8'h00, 8'h00, 1'b0});
        tbl.push_back('{1'b1, 8'h81, 1'b0,  2, 8'h00, 8'h00, 1'b0});
        tbl.push_back('{1'b1, 8'h81, 1'b0,  1, 8'h81, 8'h81, 1'b1});
        tbl.push_back('{1'b1, 8'h81, 1'b1,  1, 8'h81, 8'h00, 1'b0});
        tbl.push_back('{1'b1, 8'h80, 1'b0,  1, 8'h81, 8'h00, 1'b0});
        tbl.push_back('{1'b1, 8'h81, 1'b0,  1, 8'h81, 8'h00, 1'b0});
        tbl.push_back('{1'b1, 8'h81, 1'b0,  1, 8'h80, 8'h01, 1'b1});
        tbl.push_back('{1'b1, 8'h81, 1'b0,  1, 8'h81, 8'h01, 1'b1});
        tbl.push_back('{1'b1, 8'h83, 1'b1,  2, 8'h81, 8'h00, 1'b0});
        tbl.push_back('{1'b1, 8'h83, 1'b1,  1, 8'h83, 8'h02, 1'b1});
        tbl.push_back('{1'b1, 8'h83, 1'b1,  1, 8'h83, 8'h00, 1'b0});
        tbl.push_back('{1'b0, 8'hFF, 1'b0,  1, 8'h00, 8'h00, 1'b0});
        tbl.push_back('{1'b1, 8'hFF, 1'b0,  2, 8'h00, 8'h00, 1'b0});
        tbl.push_back('{1'b1, 8'hFF, 1'b0,  1, 8'hFF, 8'hFF, 1'b1});
`endif

        foreach (tbl[k]) begin
            for (int c = 0; c < tbl[k].n; c++) begin
                step(tbl[k].rn, tbl[k].raw, tbl[k].ack);
            end
            chk($sformatf("vec%0d_sw", k), bus.sw, tbl[k].sw);
            chk($sformatf("vec%0d_ev", k), bus.sw_event, tbl[k].ev);
            chk($sformatf("vec%0d_valid", k),
                {7'd0, bus.ev_valid}, {7'd0, tbl[k].v});
        end

        // Random phase: sparse bit flips so some changes outlast the hold
        // time and others are filtered as glitches.
        raw = bus.sw_raw;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                raw[$urandom_range(0, W - 1)] ^= 1'b1;
            end
            ack = ($urandom_range(0, 7) == 0);
            rn  = ($urandom_range(0, 599) != 0);
            step(rn, raw, ack);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sw_input_port.md
SW_INPUT_PORT -- requirements
Module: sw_input_port

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter WIDTH, default 8: number of switch bits.
REQ-003 Parameter DB_CYCLES, default 10: debounce hold count in clock cycles, legal range 2..255.
REQ-004 Port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1 bit: synchronous reset, active low.
REQ-006 Port sw_raw, input, WIDTH bits: asynchronous board switch levels.
REQ-007 Port ev_ack, input, 1 bit: one-cycle consumer acknowledge of pending change events.
REQ-008 Port sw, output, WIDTH bits: debounced switch levels; feeds the processor switch input directly.
REQ-009 Port sw_event, output, WIDTH bits: per-bit sticky flags, set when the matching sw bit toggles.
REQ-010 Port ev_valid, output, 1 bit: OR-reduction of sw_event.

Function
REQ-011 Each sw_raw bit SHALL pass through a two-flop synchronizer (s1, s2) before any other logic uses it.
REQ-012 Each bit SHALL have its own counter of ceil(log2(DB_CYCLES)) bits.
REQ-013 Per bit, per edge, the counter SHALL behave as follows:
- s2 == sw: counter cleared to 0.
- s2 != sw and counter == DB_CYCLES-1: sw bit <= s2, counter <= 0.
- otherwise: counter increments by 1.
REQ-014 A sw_raw change first sampled at edge N and held constant SHALL appear on sw at edge N+1+DB_CYCLES (2+DB_CYCLES edges, inclusive of N).
REQ-015 A sw_raw pulse whose s2 image lasts fewer than DB_CYCLES cycles SHALL leave sw and sw_event unchanged, and SHALL leave the counter at 0 once s2 returns.
REQ-016 Bits SHALL debounce independently; a change on one bit never resets another bit's counter.
REQ-017 On the edge where a sw bit toggles, the matching sw_event bit SHALL be set, registered, and visible together with the new sw value.
REQ-018 ev_ack high at an edge SHALL clear every sw_event bit that is not set by a toggle at that same edge.
REQ-019 On a simultaneous toggle and ev_ack, the set SHALL win and the bit remains 1.
REQ-020 ev_ack while ev_valid=0 SHALL have no effect.
REQ-021 A held ev_ack SHALL clear again on every edge; no error is flagged.
REQ-022 ev_valid SHALL be a combinational OR of the registered sw_event, adding no extra latency.

Reset
REQ-023 With rst_n=0 at an edge, the block SHALL clear s1, s2, sw, sw_event and all counters to 0; ev_valid is then 0.
REQ-024 Reset asserted mid-count SHALL discard the partial count; after release, a held input needs the full 2+DB_CYCLES edges.
REQ-025 After release, a switch already high SHALL debounce like a normal 0->1 change and set its sw_event bit.

Configuration
REQ-026 Macro SW_DEBOUNCE_EN defined: the counters and the timing of REQ-012..REQ-015 SHALL be compiled in.
REQ-027 SW_DEBOUNCE_EN undefined: counters SHALL be omitted, sw <= s2 every edge, raw-to-sw latency is 3 edges, no glitch filtering occurs, and event and ack behaviour is unchanged.

Verification (default parameters, SW_DEBOUNCE_EN defined unless stated)
REQ-028 Reset, then sw_raw=0x04 held from edge 1 -> sw=0x00 through edge 11, sw=0x04 and sw_event=0x04 and ev_valid=1 at edge 12.
REQ-029 From stable sw=0x04, sw_raw bit0 high for 5 cycles -> sw stays 0x04 and sw_event is unchanged.
REQ-030 sw_event=0x04, ev_ack pulsed 1 cycle -> sw_event=0x00 and ev_valid=0 next cycle; a further ev_ack has no effect.
REQ-031 Bit1 toggle completes on the same edge as ev_ack while sw_event=0x04 -> sw_event=0x02 afterwards.
REQ-032 sw_raw=0xFF held, rst_n=0 for one edge after 6 cycles -> all outputs 0, then sw=0xFF exactly 12 edges after release.
REQ-033 SW_DEBOUNCE_EN undefined, sw_raw 0x00->0x81 -> sw=0x81 on the 3rd edge and a 1-cycle glitch propagates to sw.
